// File: rtl/aura_pkg.sv
// Shared types and width constants for the embedding datapath.
// Macro defaults mirror include/sys_defs.svh so the block also builds on its own.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

package aura_pkg;

   localparam int VEC_LEN_DEF = `MAX_EMBEDDING_DIM;
   localparam int W_ELEM_DEF  = 2 * `INTEGER_WIDTH;

   localparam int IDX_W = $clog2(VEC_LEN_DEF);
   localparam int LEN_W = $clog2(VEC_LEN_DEF + 1);

   typedef logic signed [W_ELEM_DEF-1:0] elem_t;

endpackage

// File: rtl/vector_packer_if.sv
// Element stream in, assembled vector stream out, for the vector packer.
// Slot i of list_out occupies bits [i*W_ELEM +: W_ELEM]; slot 0 is the first element.
interface vector_packer_if #(
   parameter int VEC_LEN = aura_pkg::VEC_LEN_DEF,
   parameter int W_ELEM  = aura_pkg::W_ELEM_DEF
);

   logic                               vld_in;
   logic                               rdy_out;
   logic signed [W_ELEM-1:0]           elem_in;
   logic                               last_in;
   logic                               vld_out;
   logic                               rdy_in;
   logic [VEC_LEN-1:0][W_ELEM-1:0]     list_out;
   logic [$clog2(VEC_LEN+1)-1:0]       len_out;

   // Packer side: consumes elements and downstream ready, produces vectors.
   modport slave (
      input  vld_in, elem_in, last_in, rdy_in,
      output rdy_out, vld_out, list_out, len_out
   );

   // Environment side: the upstream producer plus the downstream consumer.
   modport master (
      output vld_in, elem_in, last_in, rdy_in,
      input  rdy_out, vld_out, list_out, len_out
   );

endinterface

// File: rtl/vector_packer.sv
// Packs a stream of signed elements into VEC_LEN-wide vectors for the reduction pipeline.
// Define VECTOR_PACKER_FLUSH_EN to let last_in close a partial vector early.
module vector_packer
   import aura_pkg::*;
#(
   parameter int VEC_LEN = VEC_LEN_DEF,
   parameter int W_ELEM  = W_ELEM_DEF
) (
   input logic            clk,
   input logic            rst,
   vector_packer_if.slave bus
);

   localparam int IDX_BITS = $clog2(VEC_LEN);
   localparam int LEN_BITS = $clog2(VEC_LEN + 1);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(VEC_LEN - 1);

   logic [IDX_BITS-1:0]             idx_q,  idx_d;
   logic [VEC_LEN-1:0][W_ELEM-1:0]  slot_q, slot_d;
   logic [VEC_LEN-1:0][W_ELEM-1:0]  list_q, list_d;
   logic [LEN_BITS-1:0]             len_q,  len_d;
   logic                            vld_q,  vld_d;

   logic rdyOut;
   logic accept;
   logic complete;

`ifdef VECTOR_PACKER_FLUSH_EN
   // With flush, any accept may complete, so a held vector blocks all input.
   assign rdyOut   = !vld_q || bus.rdy_in;
   assign accept   = bus.vld_in && rdyOut;
   assign complete = accept && ((idx_q == LAST_IDX) || bus.last_in);
`else
   logic unusedLast;
   assign unusedLast = bus.last_in;

   // Without flush only slot VEC_LEN-1 completes, so earlier slots keep filling.
   assign rdyOut   = !vld_q || bus.rdy_in || (idx_q != LAST_IDX);
   assign accept   = bus.vld_in && rdyOut;
   assign complete = accept && (idx_q == LAST_IDX);
`endif

   // Next-state: drain the held vector, then fold in this cycle's element.
   always_comb begin
      idx_d  = idx_q;
      slot_d = slot_q;
      list_d = list_q;
      len_d  = len_q;
      vld_d  = vld_q;

      if (vld_q && bus.rdy_in) begin
         vld_d = 1'b0;
      end

      if (accept) begin
         if (complete) begin
            list_d         = slot_q;
            list_d[idx_q]  = bus.elem_in;
            len_d          = LEN_BITS'(idx_q) + LEN_BITS'(1);
            vld_d          = 1'b1;
            slot_d         = '0;
            idx_d          = '0;
         end else begin
            slot_d[idx_q]  = bus.elem_in;
            idx_d          = idx_q + IDX_BITS'(1);
         end
      end
   end

   // State registers with synchronous reset; cleared slots keep flushed tails zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         slot_q <= '0;
         list_q <= '0;
         len_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         slot_q <= slot_d;
         list_q <= list_d;
         len_q  <= len_d;
         vld_q  <= vld_d;
      end
   end

   assign bus.rdy_out  = rdyOut;
   assign bus.vld_out  = vld_q;
   assign bus.list_out = list_q;
   assign bus.len_out  = len_q;

endmodule

// File: tb/tb_vector_packer.sv
// Scoreboard bench for vector_packer at VEC_LEN=4, W_ELEM=16.
// Expectations follow VECTOR_PACKER_FLUSH_EN when it is defined for the build.
module tb_vector_packer;
   import aura_pkg::*;

   localparam int VL = 4;
   localparam int WE = 16;

`ifdef VECTOR_PACKER_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   typedef struct packed {
      logic [VL*WE-1:0] list;
      logic [2:0]       len;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   exp_t  expQ[$];
   exp_t  monE;
   elem_t modelSlots[VL];
   int    modelCnt = 0;

   vector_packer_if #(.VEC_LEN(VL), .W_ELEM(WE)) bus();

   vector_packer #(.VEC_LEN(VL), .W_ELEM(WE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [VL*WE-1:0] pack4(elem_t a, elem_t b, elem_t c, elem_t d);
      return {d, c, b, a};
   endfunction

   // Reference packer: builds each expected vector as elements are accepted.
   task automatic modelAccept(input elem_t v, input logic l);
      exp_t e;
      modelSlots[modelCnt] = v;
      modelCnt++;
      if (modelCnt == VL || (FLUSH && l)) begin
         e.list = '0;
         for (int i = 0; i < modelCnt; i++) e.list[i*WE +: WE] = modelSlots[i];
         e.len = 3'(modelCnt);
         expQ.push_back(e);
         modelCnt = 0;
      end
   endtask

   // Each downstream transfer is compared against the oldest expected vector.
   always @(negedge clk) begin
      if (!rst && bus.vld_out && bus.rdy_in) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_vector list=%h len=%0d required=none", bus.list_out, bus.len_out);
         end else begin
            monE = expQ.pop_front();
            checks++;
            if (bus.list_out !== monE.list) begin
               errors++;
               $display("[TB] FAIL vector_list got=%h required=%h", bus.list_out, monE.list);
            end
            checks++;
            if (bus.len_out !== monE.len) begin
               errors++;
               $display("[TB] FAIL vector_len got=%0d required=%0d", bus.len_out, monE.len);
            end
         end
      end
   end

   task automatic toEdge();
      @(posedge clk);
      #1;
   endtask

   // Offer one element; returns at posedge+1 after it is accepted.
   task automatic applyStimulus(input elem_t v, input logic l, output int stalls);
      logic ok;
      ok = 1'b0;
      stalls = 0;
      bus.vld_in  = 1'b1;
      bus.elem_in = v;
      bus.last_in = l;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.rdy_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
         stalls++;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL accept_timeout elem=%h rdy_out=%b required=1", v, bus.rdy_out);
      end
      toEdge();
      if (ok) modelAccept(v, l);
      bus.vld_in  = 1'b0;
      bus.last_in = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (expQ.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s_drain pending=%0d required=0", name, expQ.size());
      end
      toEdge();
   endtask

   task automatic test_reset();
      bus.vld_in  = 1'b0;
      bus.elem_in = '0;
      bus.last_in = 1'b0;
      bus.rdy_in  = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      modelCnt = 0;
      expQ.delete();
      @(negedge clk);
      checks++;
      if (bus.vld_out !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_vld got=%b required=0", bus.vld_out);
      end
      checks++;
      if (bus.list_out !== '0) begin
         errors++; $display("[TB] FAIL reset_list got=%h required=0", bus.list_out);
      end
      checks++;
      if (bus.len_out !== 3'd0) begin
         errors++; $display("[TB] FAIL reset_len got=%0d required=0", bus.len_out);
      end
      checks++;
      if (bus.rdy_out !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_rdy got=%b required=1", bus.rdy_out);
      end
      toEdge();
   endtask

   task automatic test_basic();
      int s;
      bus.rdy_in = 1'b1;
      for (int i = 1; i <= 4; i++) applyStimulus(elem_t'(i), 1'b0, s);
      @(negedge clk);
      checks++;
      if (bus.vld_out !== 1'b1) begin
         errors++; $display("[TB] FAIL basic_vld_rise got=%b required=1", bus.vld_out);
      end
      @(negedge clk);
      checks++;
      if (bus.vld_out !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_vld_fall got=%b required=0", bus.vld_out);
      end
      waitDrain("basic");
   endtask

   task automatic test_hold();
      int s;
      logic [VL*WE-1:0] held;
      held = pack4(16'sd1, 16'sd2, 16'sd3, 16'sd4);
      bus.rdy_in = 1'b0;
      for (int i = 1; i <= 4; i++) applyStimulus(elem_t'(i), 1'b0, s);
      if (!FLUSH) begin
         for (int i = 5; i <= 7; i++) begin
            applyStimulus(elem_t'(i), 1'b0, s);
            checks++;
            if (s != 0) begin
               errors++; $display("[TB] FAIL hold_accept elem=%0d stalls=%0d required=0", i, s);
            end
         end
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.rdy_out !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_rdy got=%b required=0", bus.rdy_out);
         end
         checks++;
         if (bus.vld_out !== 1'b1 || bus.list_out !== held || bus.len_out !== 3'd4) begin
            errors++;
            $display("[TB] FAIL hold_stable vld=%b list=%h len=%0d required vld=1 list=%h len=4",
                     bus.vld_out, bus.list_out, bus.len_out, held);
         end
      end
      toEdge();
      bus.rdy_in = 1'b1;
      if (FLUSH) begin
         for (int i = 5; i <= 8; i++) applyStimulus(elem_t'(i), 1'b0, s);
      end else begin
         applyStimulus(16'sd8, 1'b0, s);
      end
      waitDrain("hold");
   endtask

   task automatic test_back_to_back();
      int s;
      int total;
      total = 0;
      bus.rdy_in = 1'b1;
      for (int i = 10; i <= 17; i++) begin
         applyStimulus(elem_t'(i), 1'b0, s);
         total += s;
      end
      checks++;
      if (total != 0) begin
         errors++; $display("[TB] FAIL b2b_stalls got=%0d required=0", total);
      end
      waitDrain("b2b");
   endtask

   task automatic test_flush();
      int s;
      logic sawVld;
      bus.rdy_in = 1'b1;
      applyStimulus(16'sd5, 1'b0, s);
      applyStimulus(16'sd6, 1'b1, s);
      if (FLUSH) begin
         waitDrain("flush_partial");
         for (int i = 9; i <= 12; i++) applyStimulus(elem_t'(i), 1'b0, s);
      end else begin
         sawVld = 1'b0;
         repeat (3) begin
            @(negedge clk);
            if (bus.vld_out !== 1'b0) sawVld = 1'b1;
         end
         checks++;
         if (sawVld) begin
            errors++; $display("[TB] FAIL flush_ignored vld_seen=%b required=0", sawVld);
         end
         toEdge();
         applyStimulus(16'sd7, 1'b0, s);
         applyStimulus(16'sd8, 1'b0, s);
      end
      waitDrain("flush");
   endtask

   task automatic test_signed();
      int s;
      bus.rdy_in = 1'b1;
      applyStimulus(16'shFFFF, 1'b0, s);
      applyStimulus(16'sh8000, 1'b0, s);
      applyStimulus(16'sh0007, 1'b0, s);
      applyStimulus(16'sh0000, 1'b0, s);
      waitDrain("signed");
   endtask

   task automatic test_reset_midfill();
      int s;
      bus.rdy_in = 1'b1;
      applyStimulus(16'shAAAA, 1'b0, s);
      applyStimulus(16'sh5555, 1'b0, s);
      rst = 1'b1;
      toEdge();
      rst = 1'b0;
      modelCnt = 0;
      @(negedge clk);
      checks++;
      if (bus.rdy_out !== 1'b1 || bus.vld_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midfill_reset rdy=%b vld=%b required rdy=1 vld=0", bus.rdy_out, bus.vld_out);
      end
      toEdge();
      if (FLUSH) begin
         applyStimulus(16'sd1, 1'b0, s);
         applyStimulus(16'sd2, 1'b1, s);
         waitDrain("midfill_flush");
      end
      for (int i = 1; i <= 4; i++) applyStimulus(elem_t'(i), 1'b0, s);
      waitDrain("midfill");
   endtask

   initial begin
      $display("[TB] vector_packer bench, flush=%0d", FLUSH);
      test_reset();
      test_basic();
      test_hold();
      test_back_to_back();
      test_flush();
      test_signed();
      test_reset_midfill();
      repeat (3) toEdge();
      checks++;
      if (expQ.size() != 0) begin
         errors++; $display("[TB] FAIL final_queue pending=%0d required=0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
